// File: rtl/dec_nx_scan.sv
// Registered N-to-2^N decoder with one-hot, thermometer and prescaled auto-scan modes.
// All outputs come straight from flops; inputs reach y one clock later.
module dec_nx_scan #(
    parameter int unsigned N  = 3,
    parameter int unsigned PW = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [1:0]        mode,
    input  logic [N-1:0]      i,
    input  logic              load,
    input  logic [PW-1:0]     period,
    output logic [2**N-1:0]   y,
    output logic              y_valid,
    output logic [N-1:0]      idx,
    output logic              wrap
);

    localparam int unsigned W = 2**N;
    localparam logic [W-1:0] ONE = W'(1);

    typedef enum logic [1:0] {
        MODE_ONEHOT = 2'b00,
        MODE_THERMO = 2'b01,
        MODE_SCAN   = 2'b10,
        MODE_RSVD   = 2'b11
    } mode_e;

    mode_e         mode_in, mode_q, mode_d;
    logic [W-1:0]  y_q, y_d;
    logic          y_valid_q, y_valid_d;
    logic [N-1:0]  idx_q, idx_d;
    logic          wrap_q, wrap_d;
    logic [PW-1:0] cnt_q, cnt_d;

    logic [PW-1:0] cnt_eff;
    logic [N-1:0]  idx_inc;
    logic [W-1:0]  thermo;

    assign mode_in = mode_e'(mode);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q    <= MODE_ONEHOT;
            y_q       <= '0;
            y_valid_q <= 1'b0;
            idx_q     <= '0;
            wrap_q    <= 1'b0;
            cnt_q     <= '0;
        end else begin
            mode_q    <= mode_d;
            y_q       <= y_d;
            y_valid_q <= y_valid_d;
            idx_q     <= idx_d;
            wrap_q    <= wrap_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        mode_d    = mode_in;
        y_d       = y_q;
        y_valid_d = 1'b0;
        idx_d     = idx_q;
        wrap_d    = 1'b0;
        // A mode change clears the prescaler in the same cycle, so the scan
        // compare below already sees the cleared value.
        cnt_eff   = (mode_in != mode_q) ? '0 : cnt_q;
        cnt_d     = cnt_eff;
        idx_inc   = idx_q + N'(1);

        thermo = '0;
        for (int unsigned k = 0; k < W; k++) begin
            thermo[k] = (k <= 32'(i));
        end

        case (mode_in)
            MODE_ONEHOT: begin
                if (en) begin
                    y_d       = ONE << i;
                    idx_d     = i;
                    y_valid_d = 1'b1;
                end
            end
            MODE_THERMO: begin
                if (en) begin
                    y_d       = thermo;
                    idx_d     = i;
                    y_valid_d = 1'b1;
                end
            end
            MODE_SCAN: begin
                if (load) begin
                    y_d       = ONE << i;
                    idx_d     = i;
                    cnt_d     = '0;
                    y_valid_d = 1'b1;
                end else if (en && (cnt_eff == period)) begin
                    y_d       = ONE << idx_inc;
                    idx_d     = idx_inc;
                    cnt_d     = '0;
                    y_valid_d = 1'b1;
                    wrap_d    = (idx_q == '1);
                end else if (en) begin
                    cnt_d = cnt_eff + PW'(1);
                end
            end
            default: begin
                y_d   = '0;
                cnt_d = '0;
            end
        endcase
    end

    assign y       = y_q;
    assign y_valid = y_valid_q;
    assign idx     = idx_q;
    assign wrap    = wrap_q;

endmodule

// File: tb/tb_dec_nx_scan.sv
// Scoreboard bench for dec_nx_scan: a cycle model predicts each output set,
// queues it at drive time and compares it one clock later; a 4-bit instance covers width scaling.
module tb_dec_nx_scan;

    logic        clk;
    logic        rst_n;
    logic        en, load;
    logic [1:0]  mode;
    logic [2:0]  i;
    logic [7:0]  period;
    logic [7:0]  y;
    logic        y_valid, wrap;
    logic [2:0]  idx;

    logic        en2, load2;
    logic [1:0]  mode2;
    logic [3:0]  i2;
    logic [3:0]  period2;
    logic [15:0] y2;
    logic        y_valid2, wrap2;
    logic [3:0]  idx2;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [7:0] y;
        logic       v;
        logic [2:0] idx;
        logic       w;
    } exp_t;

    exp_t sb[$];

    int m_y, m_idx, m_cnt, m_mode;

    dec_nx_scan #(.N(3), .PW(8)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .i(i), .load(load),
        .period(period), .y(y), .y_valid(y_valid), .idx(idx), .wrap(wrap)
    );

    dec_nx_scan #(.N(4), .PW(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .en(en2), .mode(mode2), .i(i2), .load(load2),
        .period(period2), .y(y2), .y_valid(y_valid2), .idx(idx2), .wrap(wrap2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_y = 0; m_idx = 0; m_cnt = 0; m_mode = 0;
    endtask

    // One clock: drive at negedge, predict, queue, then compare just after the posedge.
    task automatic drive(input int md, input bit e, input bit ld, input int ii, input int per);
        exp_t ex;
        exp_t got;
        int   c;
        @(negedge clk);
        mode = 2'(md); en = e; load = ld; i = 3'(ii); period = 8'(per);
        c = (md != m_mode) ? 0 : m_cnt;
        ex.v = 1'b0;
        ex.w = 1'b0;
        case (md)
            0: if (e) begin m_y = 1 << ii; m_idx = ii; ex.v = 1'b1; end
            1: if (e) begin m_y = (1 << (ii + 1)) - 1; m_idx = ii; ex.v = 1'b1; end
            2: begin
                if (ld) begin
                    m_y = 1 << ii; m_idx = ii; c = 0; ex.v = 1'b1;
                end else if (e && c == per) begin
                    ex.w  = (m_idx == 7);
                    m_idx = (m_idx + 1) % 8;
                    m_y   = 1 << m_idx;
                    c     = 0;
                    ex.v  = 1'b1;
                end else if (e) begin
                    c = (c + 1) % 256;
                end
            end
            default: begin m_y = 0; c = 0; end
        endcase
        m_cnt  = c;
        m_mode = md;
        ex.y   = 8'(m_y);
        ex.idx = 3'(m_idx);
        sb.push_back(ex);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk("sb_empty", 1, 0);
        end else begin
            got = sb.pop_front();
            chk("y",       32'(y),       32'(got.y));
            chk("y_valid", 32'(y_valid), 32'(got.v));
            chk("idx",     32'(idx),     32'(got.idx));
            chk("wrap",    32'(wrap),    32'(got.w));
        end
    endtask

    initial begin
        rst_n = 1'b0;
        en = 0; load = 0; mode = 0; i = 0; period = 0;
        en2 = 0; load2 = 0; mode2 = 0; i2 = 0; period2 = 0;
        model_reset();
        #12;
        chk("rst_y",    32'(y),       0);
        chk("rst_v",    32'(y_valid), 0);
        chk("rst_idx",  32'(idx),     0);
        chk("rst_wrap", 32'(wrap),    0);
        @(negedge clk);
        rst_n = 1'b1;

        drive(0, 0, 0, 3, 0);
        for (int k = 0; k < 8; k++) drive(0, 1, 0, k, 0);

        drive(1, 1, 0, 0, 0);
        drive(1, 1, 0, 3, 0);
        drive(1, 1, 0, 7, 0);
        chk("thermo_full", 32'(y), 32'hFF);
        drive(1, 0, 0, 5, 0);

        drive(2, 1, 1, 6, 2);
        chk("scan_load", 32'(y), 32'h40);
        for (int k = 0; k < 6; k++) drive(2, 1, 0, 0, 2);
        chk("scan_wrap_y", 32'(y), 32'h01);

        for (int k = 0; k < 10; k++) drive(2, 1, 0, 0, 0);
        for (int k = 0; k < 4; k++)  drive(2, 0, 0, 0, 0);
        for (int k = 0; k < 10; k++) drive(2, 1, 0, 0, 0);

        drive(2, 1, 1, 0, 5);
        for (int k = 0; k < 4; k++)   drive(2, 1, 0, 0, 5);
        for (int k = 0; k < 260; k++) drive(2, 1, 0, 0, 1);

        drive(0, 1, 0, 4, 0);
        for (int k = 0; k < 3; k++) drive(2, 1, 0, 0, 1);

        for (int k = 0; k < 300; k++)
            drive($urandom_range(0, 3), ($urandom % 4) != 0, ($urandom % 5) == 0,
                  $urandom_range(0, 7), $urandom_range(0, 3));

        drive(2, 1, 1, 2, 3);
        drive(2, 1, 0, 0, 3);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_y",    32'(y),       0);
        chk("async_idx",  32'(idx),     0);
        chk("async_v",    32'(y_valid), 0);
        chk("async_wrap", 32'(wrap),    0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 0);
        drive(0, 1, 0, 5, 0);
        drive(3, 1, 0, 2, 0);
        drive(3, 1, 1, 2, 0);
        drive(2, 1, 0, 0, 0);

        @(negedge clk);
        mode2 = 2'b00; en2 = 1'b1; i2 = 4'd15;
        @(posedge clk); #1;
        chk("n4_onehot_y",   32'(y2),       32'h8000);
        chk("n4_onehot_idx", 32'(idx2),     15);
        chk("n4_onehot_v",   32'(y_valid2), 1);
        @(negedge clk);
        mode2 = 2'b10; load2 = 1'b1; i2 = 4'd15; period2 = 4'd0;
        @(posedge clk); #1;
        chk("n4_load_y",    32'(y2),   32'h8000);
        chk("n4_load_wrap", 32'(wrap2), 0);
        @(negedge clk);
        load2 = 1'b0;
        @(posedge clk); #1;
        chk("n4_step_y",    32'(y2),       32'h0001);
        chk("n4_step_wrap", 32'(wrap2),    1);
        chk("n4_step_idx",  32'(idx2),     0);
        chk("n4_step_v",    32'(y_valid2), 1);
        @(negedge clk);
        en2 = 1'b0;
        @(posedge clk); #1;
        chk("n4_wrap_pulse", 32'(wrap2), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

endmodule

// File: doc/dec_nx_scan.md
Name: dec_nx_scan

Overview:
Parametrised, registered binary decoder: the successor to the team's 3-to-8 combinational decoder. It decodes an N-bit index into 2^N lines in one of three modes: one-hot, thermometer, or auto-scan (a walking one advanced by a programmable prescaler). It drives row/column select, LED scan and chip-select fan-out in the ADIC lab designs. All outputs are registered.

Parameters:
N, 3, index width; output width is 2^N
PW, 8, width of the scan-period prescaler

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
en  input  1  update enable (decode/thermo) or count enable (scan)
mode  input  2  00 one-hot decode, 01 thermometer, 10 auto-scan, 11 reserved
i  input  N  index input; scan start index on load
load  input  1  scan mode only: restart scan at index i
period  input  PW  scan mode: cycles per step minus one
y  output  2^N  decoded output
y_valid  output  1  one-cycle pulse: y was updated this cycle
idx  output  N  index currently driven on y
wrap  output  1  one-cycle pulse: scan stepped from 2^N-1 to 0

Behaviour:
- Reset (rst_n low, asynchronous): y=0, y_valid=0, idx=0, wrap=0, internal prescaler cnt=0, internal mode_q=00.
- Register boundary: all outputs update on the clk rising edge; latency from input to y is 1 cycle.
- mode_q holds the registered copy of mode. When mode != mode_q, cnt is cleared that cycle.
- Mode 00 (one-hot):
  - en=1: y<=1<<i, idx<=i, y_valid<=1.
  - en=0: y and idx hold, y_valid<=0.
- Mode 01 (thermometer):
  - en=1: y bits 0..i set, all others clear (i=0 gives ...0001; i=2^N-1 gives all ones); idx<=i; y_valid<=1.
  - en=0: y and idx hold, y_valid<=0.
- Mode 10 (auto-scan):
  - load=1 (highest priority; en ignored): idx<=i, y<=1<<i, cnt<=0, y_valid<=1, wrap<=0.
  - Else if en=1 and cnt==period: cnt<=0, idx<=idx+1 modulo 2^N, y<=1<<(idx+1), y_valid<=1. wrap<=1 only when idx was 2^N-1.
  - Else if en=1: cnt<=cnt+1, y holds, y_valid<=0, wrap<=0.
  - en=0 without load: freeze cnt, idx and y; y_valid=0, wrap=0.
  - period=0: steps every enabled cycle.
  - period changed mid-count: takes effect at the next compare. If cnt>period, cnt counts up to 2^PW-1, rolls to 0, then matches.
- Mode 11 (reserved): y<=0, y_valid<=0, wrap<=0, idx holds, cnt<=0.
- Entering scan from another mode without load: scan continues from the current idx. If y is not one-hot, y is overwritten at the first step.
- y_valid and wrap are single-cycle pulses and are never high in the cycle after reset release unless an update occurs.
- Reset asserted mid-scan: all state clears immediately. After release, the block needs load or a decode to resume.
- All arithmetic is unsigned. idx increment wraps naturally at N bits.

Test Plan:
- Reset → y=0, idx=0, y_valid=0, wrap=0. Mode 00, en=1, i swept 0..7 (N=3) → y=01,02,04,…,80 one cycle after each i, y_valid=1 each cycle.
- Mode 01, en=1, i=0,3,7 → y=0x01, 0x0F, 0xFF. Then en=0, i=5 → y stays 0xFF, y_valid=0.
- Mode 10, load with i=6, period=2, en=1 → y=0x40; 3 cycles later y=0x80; 3 cycles later y=0x01 with wrap=1 for one cycle; y_valid pulses only on the steps.
- Mode 10, period=0, en=1, no load, starting idx=0 → y walks 01,02,…,80,01 every cycle; wrap pulses every 8 cycles. Mid-run en=0 for 4 cycles → y frozen, no pulses.
- Mode 10 with cnt=1, drive rst_n low asynchronously mid-scan → y=0, idx=0 immediately without a clock edge. Mode 11 → y=0, y_valid=0.
- N=4, PW=4 instance: mode 00, i=15 → y=0x8000. Mode 10, load i=15, period=0 → next step y=0x0001, wrap=1.
